// File: rtl/row_buffer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// row_buffer_ctrl_pkg
// Types and constants shared by row_buffer_ctrl and its raster counter.
//   state_t      controller states
//   INIT_CYCLES  number of cycles rb_initialize is held high
// ---------------------------------------------------------------------------
package row_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // row_buffer registers delay-K internally, so the new delay needs two
    // cycles of initialize before the first pixel arrives.
    localparam int unsigned INIT_CYCLES = 2;

endpackage

// File: rtl/row_buffer_ctrl_raster_counter.sv
// ---------------------------------------------------------------------------
// row_buffer_ctrl_raster_counter
// Column/row position counter for a raster scan. Advances on en, wraps the
// column at col_last and the row at row_last.
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear to (0,0)
//   en            advance one pixel
//   col_last      last column index (cols-1)
//   row_last      last row index (rows-1)
//   col, row      current position (coordinates of the next pixel)
//   last          current position is the final pixel of the frame
// ---------------------------------------------------------------------------
module row_buffer_ctrl_raster_counter
    import row_buffer_ctrl_pkg::*;
#(
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [COL_W-1:0] col_last,
    input  logic [ROW_W-1:0] row_last,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col == col_last);
    assign row_wrap = (row == row_last);
    assign last     = col_wrap && row_wrap;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// row_buffer_ctrl
// Sequences one row_buffer (K-tap window plus line delay) over a raster
// frame: latches geometry on cfg_start, programs the line delay, pulses
// initialize, gates upstream pixels into the buffer and flags cycles where
// the window holds a complete KxK patch.
//   clk, rst          clock, synchronous active-high reset
//   cfg_start         latch cfg_num_cols/rows and begin a frame (IDLE only)
//   cfg_num_cols/rows frame geometry
//   cfg_busy          frame in progress (INIT, RUN, DONE)
//   cfg_error         sticky bad-geometry flag, cleared by the next start
//   pix_valid/ready   upstream pixel handshake
//   rb_initialize     row_buffer.initialize
//   rb_delay          row_buffer.delay (line length)
//   rb_datain_valid   row_buffer.datain_valid
//   win_valid         window holds a full KxK patch (1 cycle after accept)
//   win_col/win_row   coordinates of the newest pixel in that window
//   frame_done        one-cycle pulse after the last pixel is accepted
//
// state | meaning
// IDLE  | waiting for a legal cfg_start
// INIT  | rb_initialize held for INIT_CYCLES, counters cleared
// RUN   | accepting pixels until the last one of the frame
// DONE  | one-cycle frame_done, then back to IDLE
// ---------------------------------------------------------------------------
module row_buffer_ctrl
    import row_buffer_ctrl_pkg::*;
#(
    parameter int C_KERNEL_SIZE = 5,
    parameter int C_MAX_DELAY   = 1024,
    parameter int C_PTR_WIDTH   = $clog2(C_MAX_DELAY),
    parameter int C_MAX_ROWS    = 1024,
    parameter int C_ROW_WIDTH   = $clog2(C_MAX_ROWS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [C_PTR_WIDTH-1:0] cfg_num_cols,
    input  logic [C_ROW_WIDTH-1:0] cfg_num_rows,
    output logic                   cfg_busy,
    output logic                   cfg_error,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic                   rb_initialize,
    output logic [C_PTR_WIDTH-1:0] rb_delay,
    output logic                   rb_datain_valid,
    output logic                   win_valid,
    output logic [C_PTR_WIDTH-1:0] win_col,
    output logic [C_ROW_WIDTH-1:0] win_row,
    output logic                   frame_done
);

    localparam logic [C_PTR_WIDTH-1:0] K_COL   = C_PTR_WIDTH'(C_KERNEL_SIZE);
    localparam logic [C_ROW_WIDTH-1:0] K_ROW   = C_ROW_WIDTH'(C_KERNEL_SIZE);
    localparam logic [C_PTR_WIDTH-1:0] COL_MIN = C_PTR_WIDTH'(C_KERNEL_SIZE - 1);
    localparam logic [C_ROW_WIDTH-1:0] ROW_MIN = C_ROW_WIDTH'(C_KERNEL_SIZE - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     init_cnt;
    logic                     init_last;
    logic [C_PTR_WIDTH-1:0]   cols_m1;
    logic [C_ROW_WIDTH-1:0]   rows_m1;
    logic [C_PTR_WIDTH-1:0]   col;
    logic [C_ROW_WIDTH-1:0]   row;
    logic                     last_pix;
    logic                     accept;
    logic                     win_hit;
    logic                     cols_hi_ok;
    logic                     geom_ok;

    // When the column port cannot represent C_MAX_DELAY the upper bound is
    // implied by the port width, so no comparator is built.
    generate
        if ((2 ** C_PTR_WIDTH) - 1 <= C_MAX_DELAY - 1) begin : g_cols_hi_implied
            assign cols_hi_ok = 1'b1;
        end else begin : g_cols_hi_cmp
            assign cols_hi_ok = (cfg_num_cols <= C_PTR_WIDTH'(C_MAX_DELAY - 1));
        end
    endgenerate

    assign geom_ok   = (cfg_num_cols >= K_COL) && cols_hi_ok && (cfg_num_rows >= K_ROW);
    assign init_last = (init_cnt == 1'(INIT_CYCLES - 1));
    assign accept    = pix_valid && pix_ready;
    assign win_hit   = accept && (row >= ROW_MIN) && (col >= COL_MIN);

    row_buffer_ctrl_raster_counter #(
        .COL_W (C_PTR_WIDTH),
        .ROW_W (C_ROW_WIDTH)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == ST_INIT),
        .en       (accept),
        .col_last (cols_m1),
        .row_last (rows_m1),
        .col      (col),
        .row      (row),
        .last     (last_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pix_ready       = 1'b0;
        rb_initialize   = 1'b0;
        frame_done      = 1'b0;
        cfg_busy        = 1'b1;
        case (state)
            ST_IDLE: begin
                cfg_busy = 1'b0;
                if (cfg_start && geom_ok) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                rb_initialize = 1'b1;
                if (init_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                pix_ready = 1'b1;
                if (pix_valid && last_pix) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rb_datain_valid = accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= 1'b0;
            cfg_error <= 1'b0;
            rb_delay  <= '0;
            cols_m1   <= '0;
            rows_m1   <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else begin
            init_cnt <= (state == ST_INIT) ? init_cnt + 1'b1 : 1'b0;

            // A start while busy is dropped without touching geometry or error.
            if (state == ST_IDLE && cfg_start) begin
                cfg_error <= !geom_ok;
                if (geom_ok) begin
                    rb_delay <= cfg_num_cols;
                    cols_m1  <= cfg_num_cols - 1'b1;
                    rows_m1  <= cfg_num_rows - 1'b1;
                end
            end

            win_valid <= win_hit;
            if (win_hit) begin
                win_col <= col;
                win_row <= row;
            end
        end
    end

endmodule
